// File: rtl/i2c_pwm_pkg.sv
// Shared types and constants for the I2C-controlled PWM duty register block.
package i2c_pwm_pkg;

    localparam int DUTY_W = 8;
    localparam int MAX_CH = 8;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } i2c_state_e;

    // Per-clk line events derived from the synchronised bus.
    typedef struct packed {
        logic sda;
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } line_evt_t;

    function automatic logic [2:0] ptr_next(input logic [2:0] p, input int n);
        return (p == 3'(n - 1)) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronisers for SCL/SDA plus START, STOP and SCL edge detection.
module i2c_line_sync
    import i2c_pwm_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      scl_i,
    input  logic      sda_i,
    output line_evt_t evt
);

    // [0],[1] are the synchroniser, [2] holds the previous synchronised value.
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    always_comb begin
        evt          = '0;
        evt.sda      = sda_q[1];
        evt.scl_rise = scl_q[1] & ~scl_q[2];
        evt.scl_fall = ~scl_q[1] & scl_q[2];
        evt.start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
        evt.stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    end

endmodule

// File: rtl/i2c_pwm_regs.sv
// I2C target exposing NUM_CH 8-bit PWM duty registers behind an auto-incrementing pointer.
// Read-back of the duty registers is built only when I2C_READBACK_EN is defined.
module i2c_pwm_regs
    import i2c_pwm_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h42,
    parameter int         NUM_CH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    output logic [DUTY_W*NUM_CH-1:0] duty_o,
    output logic                     wr_stb,
    output logic [2:0]               wr_idx
);

    line_evt_t  evt;
    i2c_state_e state, state_nx;
    logic       oe_nx;
    logic [3:0] bit_cnt;
    logic [7:0] sreg;
    logic [2:0] ptr;
    logic [NUM_CH-1:0][DUTY_W-1:0] duty_q;

    logic shift_in, cnt_inc, cnt_clr, ptr_ld, ptr_inc, wr_en;
    logic byte_end, addr_ok, ptr_ok;

    i2c_line_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .scl_i (scl_i),
        .sda_i (sda_i),
        .evt   (evt)
    );

    assign duty_o   = duty_q;
    assign byte_end = evt.scl_fall && (bit_cnt == 4'd8);
    assign ptr_ok   = int'(sreg) < NUM_CH;

`ifdef I2C_READBACK_EN
    logic       rw, mack;
    logic       rd_ld, shift_out, mack_ld, rw_ld;
    logic [7:0] rd_byte;

    assign addr_ok = (sreg[7:1] == I2C_ADDR);

    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ptr == 3'(i)) rd_byte = duty_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw   <= 1'b0;
            mack <= 1'b1;
        end else begin
            if (rw_ld)   rw   <= sreg[0];
            if (mack_ld) mack <= evt.sda;
        end
    end
`else
    assign addr_ok = (sreg[7:1] == I2C_ADDR) && !sreg[0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
        end else begin
            state  <= state_nx;
            sda_oe <= oe_nx;
        end
    end

    always_comb begin
        state_nx = state;
        oe_nx    = sda_oe;
        shift_in = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        ptr_ld   = 1'b0;
        ptr_inc  = 1'b0;
        wr_en    = 1'b0;
`ifdef I2C_READBACK_EN
        rd_ld     = 1'b0;
        shift_out = 1'b0;
        mack_ld   = 1'b0;
        rw_ld     = 1'b0;
`endif
        if (evt.stop) begin
            state_nx = IDLE;
            oe_nx    = 1'b0;
        end else if (evt.start) begin
            state_nx = ADDR;
            oe_nx    = 1'b0;
            cnt_clr  = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (evt.scl_rise) begin
                        shift_in = 1'b1;
                        cnt_inc  = 1'b1;
                    end else if (byte_end) begin
                        state_nx = addr_ok ? ADDR_ACK : IDLE;
                        oe_nx    = addr_ok;
`ifdef I2C_READBACK_EN
                        rw_ld    = 1'b1;
`endif
                    end
                end
                PTR: begin
                    if (evt.scl_rise) begin
                        shift_in = 1'b1;
                        cnt_inc  = 1'b1;
                    end else if (byte_end) begin
                        state_nx = ptr_ok ? PTR_ACK : IDLE;
                        oe_nx    = ptr_ok;
                        ptr_ld   = ptr_ok;
                    end
                end
                WDATA: begin
                    if (evt.scl_rise) begin
                        shift_in = 1'b1;
                        cnt_inc  = 1'b1;
                    end else if (byte_end) begin
                        state_nx = WDATA_ACK;
                        oe_nx    = 1'b1;
                        wr_en    = 1'b1;
                        ptr_inc  = 1'b1;
                    end
                end
                ADDR_ACK: begin
                    if (evt.scl_fall) begin
                        state_nx = PTR;
                        oe_nx    = 1'b0;
                        cnt_clr  = 1'b1;
`ifdef I2C_READBACK_EN
                        if (rw) begin
                            state_nx = RDATA;
                            rd_ld    = 1'b1;
                            oe_nx    = ~rd_byte[7];
                        end
`endif
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (evt.scl_fall) begin
                        state_nx = WDATA;
                        oe_nx    = 1'b0;
                        cnt_clr  = 1'b1;
                    end
                end
`ifdef I2C_READBACK_EN
                RDATA: begin
                    if (evt.scl_rise) begin
                        cnt_inc = 1'b1;
                    end else if (byte_end) begin
                        state_nx = RDATA_ACK;
                        oe_nx    = 1'b0;
                        ptr_inc  = 1'b1;
                    end else if (evt.scl_fall) begin
                        shift_out = 1'b1;
                        oe_nx     = ~sreg[6];
                    end
                end
                RDATA_ACK: begin
                    if (evt.scl_rise) begin
                        mack_ld = 1'b1;
                    end else if (evt.scl_fall) begin
                        if (!mack) begin
                            state_nx = RDATA;
                            rd_ld    = 1'b1;
                            cnt_clr  = 1'b1;
                            oe_nx    = ~rd_byte[7];
                        end else begin
                            state_nx = IDLE;
                            oe_nx    = 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    state_nx = IDLE;
                    oe_nx    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            sreg    <= '0;
            ptr     <= '0;
            duty_q  <= '0;
            wr_stb  <= 1'b0;
            wr_idx  <= '0;
        end else begin
            wr_stb <= wr_en;
            if (cnt_clr)      bit_cnt <= '0;
            else if (cnt_inc) bit_cnt <= bit_cnt + 4'd1;
            if (shift_in)     sreg <= {sreg[6:0], evt.sda};
`ifdef I2C_READBACK_EN
            else if (rd_ld)     sreg <= rd_byte;
            else if (shift_out) sreg <= {sreg[6:0], 1'b0};
`endif
            if (ptr_ld)       ptr <= sreg[2:0];
            else if (ptr_inc) ptr <= ptr_next(ptr, NUM_CH);
            // Duty is written with the pre-increment pointer in the same clk.
            if (wr_en) begin
                wr_idx <= ptr;
                for (int i = 0; i < NUM_CH; i++)
                    if (ptr == 3'(i)) duty_q[i] <= sreg;
            end
        end
    end

endmodule

// File: tb/tb_i2c_pwm_regs.sv
// Directed bench for i2c_pwm_regs: bit-banged I2C controller with open-drain SDA.
module tb_i2c_pwm_regs;

    localparam int NCH = 8;
    localparam int Q   = 6;

    logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_drv = 1'b1;
    logic sda_i, sda_oe, wr_stb;
    logic [2:0] wr_idx;
    logic [8*NCH-1:0] duty_o;
    logic [NCH-1:0][7:0] exp_duty = '0;

    int total = 0, bad = 0;
    int pulses = 0, stb_cycles = 0;
    logic [2:0] last_idx = '0;
    logic stb_prev = 1'b0, oe_seen = 1'b0;

    always #5 clk = ~clk;
    assign sda_i = sda_drv & ~sda_oe;

    i2c_pwm_regs #(.I2C_ADDR(7'h42), .NUM_CH(NCH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .scl_i  (scl),
        .sda_i  (sda_i),
        .sda_oe (sda_oe),
        .duty_o (duty_o),
        .wr_stb (wr_stb),
        .wr_idx (wr_idx)
    );

    always @(negedge clk) begin
        if (wr_stb) begin
            stb_cycles++;
            last_idx = wr_idx;
            if (!stb_prev) pulses++;
        end
        stb_prev = wr_stb;
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic wbit(input logic b);
        sda_drv = b; qwait(); scl = 1'b1; qwait(); qwait(); scl = 1'b0; qwait();
    endtask

    task automatic rbit(output logic b);
        sda_drv = 1'b1; qwait(); scl = 1'b1; qwait(); b = sda_i; qwait(); scl = 1'b0; qwait();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(b);
        ack = !b;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; qwait(); scl = 1'b1; qwait(); sda_drv = 1'b0; qwait(); scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; qwait(); scl = 1'b1; qwait(); sda_drv = 1'b1; qwait(); qwait();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (duty_o !== '0)    begin bad++; $display("FAIL rst_duty: got %h want 0", duty_o); end
        total++; if (sda_oe !== 1'b0)  begin bad++; $display("FAIL rst_oe: got %b want 0", sda_oe); end
        total++; if (wr_stb !== 1'b0)  begin bad++; $display("FAIL rst_stb: got %b want 0", wr_stb); end
        total++; if (wr_idx !== 3'd0)  begin bad++; $display("FAIL rst_idx: got %0d want 0", wr_idx); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write_basic();
        logic a0, a1, a2;
        int p0 = pulses, c0 = stb_cycles;
        i2c_start(); wbyte(8'h84, a0); wbyte(8'h02, a1); wbyte(8'h55, a2); i2c_stop();
        exp_duty[2] = 8'h55;
        total++; if (a0 !== 1'b1) begin bad++; $display("FAIL wr_addr_ack: got %b want 1", a0); end
        total++; if (a1 !== 1'b1) begin bad++; $display("FAIL wr_ptr_ack: got %b want 1", a1); end
        total++; if (a2 !== 1'b1) begin bad++; $display("FAIL wr_data_ack: got %b want 1", a2); end
        total++; if (duty_o !== exp_duty) begin bad++; $display("FAIL wr_duty: got %h want %h", duty_o, exp_duty); end
        total++; if (pulses - p0 != 1) begin bad++; $display("FAIL wr_pulses: got %0d want 1", pulses - p0); end
        total++; if (stb_cycles - c0 != 1) begin bad++; $display("FAIL wr_stb_width: got %0d want 1", stb_cycles - c0); end
        total++; if (last_idx !== 3'd2) begin bad++; $display("FAIL wr_idx: got %0d want 2", last_idx); end
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL wr_oe_after_stop: got %b want 0", sda_oe); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3;
        int p0 = pulses;
        i2c_start(); wbyte(8'h84, a0); wbyte(8'h07, a1); wbyte(8'h11, a2); wbyte(8'h22, a3); i2c_stop();
        exp_duty[7] = 8'h11; exp_duty[0] = 8'h22;
        total++; if ({a0, a1, a2, a3} !== 4'hF) begin bad++; $display("FAIL wrap_acks: got %b want 1111", {a0, a1, a2, a3}); end
        total++; if (duty_o !== exp_duty) begin bad++; $display("FAIL wrap_duty: got %h want %h", duty_o, exp_duty); end
        total++; if (pulses - p0 != 2) begin bad++; $display("FAIL wrap_pulses: got %0d want 2", pulses - p0); end
        total++; if (last_idx !== 3'd0) begin bad++; $display("FAIL wrap_idx: got %0d want 0", last_idx); end
    endtask

    task automatic test_bad_addr();
        logic a0, a1;
        int p0 = pulses;
        oe_seen = 1'b0;
        i2c_start(); wbyte(8'h86, a0); wbyte(8'h12, a1); i2c_stop();
        total++; if (a0 !== 1'b0) begin bad++; $display("FAIL badaddr_nack: got %b want 0", a0); end
        total++; if (a1 !== 1'b0) begin bad++; $display("FAIL badaddr_quiet: got %b want 0", a1); end
        total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL badaddr_oe: got %b want 0", oe_seen); end
        total++; if (duty_o !== exp_duty) begin bad++; $display("FAIL badaddr_duty: got %h want %h", duty_o, exp_duty); end
        total++; if (pulses != p0) begin bad++; $display("FAIL badaddr_pulses: got %0d want 0", pulses - p0); end
    endtask

    task automatic test_bad_ptr();
        logic a0, a1, a2;
        int p0 = pulses;
        i2c_start(); wbyte(8'h84, a0); wbyte(8'h09, a1); wbyte(8'h33, a2); i2c_stop();
        total++; if ({a0, a1, a2} !== 3'b100) begin bad++; $display("FAIL badptr_acks: got %b want 100", {a0, a1, a2}); end
        total++; if (pulses != p0) begin bad++; $display("FAIL badptr_pulses: got %0d want 0", pulses - p0); end
        total++; if (duty_o !== exp_duty) begin bad++; $display("FAIL badptr_duty: got %h want %h", duty_o, exp_duty); end
    endtask

    task automatic test_restart();
        logic a0, a1, a2;
        i2c_start(); wbit(1'b1); wbit(1'b0); wbit(1'b1);
        i2c_start(); wbyte(8'h84, a0); wbyte(8'h06, a1); wbyte(8'h77, a2); i2c_stop();
        exp_duty[6] = 8'h77;
        total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL restart_acks: got %b want 111", {a0, a1, a2}); end
        total++; if (duty_o !== exp_duty) begin bad++; $display("FAIL restart_duty: got %h want %h", duty_o, exp_duty); end
    endtask

`ifdef I2C_READBACK_EN
    task automatic rbyte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin rbit(b); d[i] = b; end
        wbit(!ack);
    endtask

    task automatic test_read();
        logic a0, a1, a2, a3, a4;
        logic [7:0] d0, d1;
        i2c_start(); wbyte(8'h84, a0); wbyte(8'h01, a1); wbyte(8'hA6, a2); i2c_stop();
        exp_duty[1] = 8'hA6;
        i2c_start(); wbyte(8'h84, a3); wbyte(8'h01, a4);
        i2c_start(); wbyte(8'h85, a0);
        rbyte(d0, 1'b1); rbyte(d1, 1'b0); i2c_stop();
        total++; if ({a1, a2, a3, a4} !== 4'hF) begin bad++; $display("FAIL rd_setup_acks: got %b want 1111", {a1, a2, a3, a4}); end
        total++; if (a0 !== 1'b1) begin bad++; $display("FAIL rd_addr_ack: got %b want 1", a0); end
        total++; if (d0 !== 8'hA6) begin bad++; $display("FAIL rd_byte0: got %h want a6", d0); end
        total++; if (d1 !== 8'h55) begin bad++; $display("FAIL rd_byte1: got %h want 55", d1); end
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rd_oe_after_stop: got %b want 0", sda_oe); end
    endtask
`else
    task automatic test_read();
        logic a0;
        i2c_start(); wbyte(8'h85, a0); i2c_stop();
        total++; if (a0 !== 1'b0) begin bad++; $display("FAIL rd_nack: got %b want 0", a0); end
        total++; if (duty_o !== exp_duty) begin bad++; $display("FAIL rd_duty: got %h want %h", duty_o, exp_duty); end
    endtask
`endif

    task automatic test_abort_stop();
        logic a0, a1, a2;
        int p0 = pulses;
        i2c_start(); wbyte(8'h84, a0); wbyte(8'h03, a1);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
        i2c_stop();
        total++; if (duty_o !== exp_duty) begin bad++; $display("FAIL abort_stop_duty: got %h want %h", duty_o, exp_duty); end
        total++; if (pulses != p0) begin bad++; $display("FAIL abort_stop_pulses: got %0d want 0", pulses - p0); end
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL abort_stop_oe: got %b want 0", sda_oe); end
        i2c_start(); wbyte(8'h84, a0); wbyte(8'h03, a1); wbyte(8'hC3, a2); i2c_stop();
        exp_duty[3] = 8'hC3;
        total++; if (duty_o !== exp_duty) begin bad++; $display("FAIL abort_stop_recover: got %h want %h", duty_o, exp_duty); end
    endtask

    task automatic test_abort_reset();
        logic a0, a1, a2, b;
        int p0 = pulses;
        i2c_start(); wbyte(8'h84, a0); wbyte(8'h04, a1);
        wbit(1'b1); wbit(1'b1); wbit(1'b1); wbit(1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_duty = '0;
        total++; if (duty_o !== exp_duty) begin bad++; $display("FAIL abort_rst_duty: got %h want 0", duty_o); end
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL abort_rst_oe: got %b want 0", sda_oe); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        wbit(1'b0); wbit(1'b0); wbit(1'b0); wbit(1'b0); rbit(b);
        total++; if (b !== 1'b1) begin bad++; $display("FAIL abort_rst_no_ack: got sda %b want 1", b); end
        total++; if (pulses != p0) begin bad++; $display("FAIL abort_rst_pulses: got %0d want 0", pulses - p0); end
        i2c_stop();
        i2c_start(); wbyte(8'h84, a0); wbyte(8'h05, a1); wbyte(8'h5A, a2); i2c_stop();
        exp_duty[5] = 8'h5A;
        total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL abort_rst_recover_acks: got %b want 111", {a0, a1, a2}); end
        total++; if (duty_o !== exp_duty) begin bad++; $display("FAIL abort_rst_recover_duty: got %h want %h", duty_o, exp_duty); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_wrap();
        test_bad_addr();
        test_bad_ptr();
        test_restart();
        test_read();
        test_abort_stop();
        test_abort_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
